// File: rtl/ddr_pim_burst_ctrl_if.sv
// Client and PIM signal bundle for ddr_pim_burst_ctrl.
// The slave modport is the controller's view; the master modport is the
// combined client + PIM side that surrounds it.
interface ddr_pim_burst_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  // Handshakes: a transfer happens on a rising clock edge where valid and
  // ready are both 1; valid is never withdrawn before the transfer, and
  // pim_addr_req stays high with a stable command until pim_addr_ack.
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_W+4:0]       req_cmd;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [DATA_W+DATA_W/8-1:0] wr_beat;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_W-1:0]       rsp_data;
  logic [ADDR_W-1:0]       pim_addr;
  logic                    pim_rnw;
  logic [3:0]              pim_size;
  logic                    pim_addr_req;
  logic                    pim_addr_ack;
  logic                    pim_rdmodwr;
  logic [DATA_W-1:0]       pim_wr_data;
  logic [DATA_W/8-1:0]     pim_wr_be;
  logic                    pim_wr_push;
  logic                    pim_wr_almost_full;
  logic                    pim_flush;
  logic [DATA_W-1:0]       pim_rd_data;
  logic                    pim_rd_pop;
  logic                    pim_rd_empty;
  logic [1:0]              pim_rd_latency;
  logic                    pim_init_done;

  modport slave (
    input  req_valid, req_cmd, wr_valid, wr_beat, rsp_ready,
    input  pim_addr_ack, pim_wr_almost_full, pim_rd_data, pim_rd_empty,
    input  pim_rd_latency, pim_init_done,
    output req_ready, wr_ready, rsp_valid, rsp_data,
    output pim_addr, pim_rnw, pim_size, pim_addr_req, pim_rdmodwr,
    output pim_wr_data, pim_wr_be, pim_wr_push, pim_flush, pim_rd_pop
  );

  modport master (
    output req_valid, req_cmd, wr_valid, wr_beat, rsp_ready,
    output pim_addr_ack, pim_wr_almost_full, pim_rd_data, pim_rd_empty,
    output pim_rd_latency, pim_init_done,
    input  req_ready, wr_ready, rsp_valid, rsp_data,
    input  pim_addr, pim_rnw, pim_size, pim_addr_req, pim_rdmodwr,
    input  pim_wr_data, pim_wr_be, pim_wr_push, pim_flush, pim_rd_pop
  );
endinterface

// File: rtl/ddr_pim_burst_ctrl.sv
// Burst sequencer between client valid/ready channels and one MPMC PIM port.
// Writes are staged straight into the PIM write FIFO, reads reserve response
// FIFO credits before their AddrReq so returned data can never overflow.
// Optional feature macro: DDR_PIM_RMW_EN (partial single-beat writes raise
// pim_rdmodwr with their AddrReq).
module ddr_pim_burst_ctrl #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int RSP_DEPTH = 16
) (
  input  logic                sys_clk_pin,
  input  logic                DDR_SDRAM_MPMC_Rst_pin,
  ddr_pim_burst_ctrl_if.slave bus,
  output logic [2:0]          o_dbg_state
);
  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CW1   = CNT_W + 1;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_WFILL = 3'd2,
    S_RCHK  = 3'd3,
    S_ADDR  = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rnw;
  logic [3:0]        r_size;
  logic [4:0]        r_beats;
  logic [4:0]        r_cnt;
  logic              r_addr_req;
  logic [1:0]        r_lat;
  logic              r_flush;
  logic [CNT_W-1:0]  r_outst;
  logic [CNT_W-1:0]  r_credits;
  logic [3:1]        r_tag;
  logic [DATA_W-1:0] r_mem [RSP_DEPTH];
  logic [CNT_W-1:0]  r_wptr;
  logic [CNT_W-1:0]  r_rptr;

  logic              w_rnw;
  logic [3:0]        w_size;
  logic [ADDR_W-1:0] w_addr;
  logic              w_size_ok;
  logic              w_req_fire;
  logic [BE_W-1:0]   w_wr_be;
  logic              w_wr_fire;
  logic              w_last_beat;
  logic              w_credit_ok;
  logic              w_reserve;
  logic [CNT_W-1:0]  w_need;
  logic              w_pop;
  logic              w_rsp_valid;
  logic              w_rsp_fire;
  logic              w_rsp_we;

  // Size code to beat count: code 0 is always a single beat.
  function automatic logic [4:0] beats_of(input logic [3:0] size);
    case (size)
      4'd0:    beats_of = 5'd1;
      4'd1:    beats_of = 5'(128 / DATA_W);
      4'd2:    beats_of = 5'(256 / DATA_W);
      default: beats_of = 5'(512 / DATA_W);
    endcase
  endfunction

  assign w_rnw       = bus.req_cmd[ADDR_W+4];
  assign w_size      = bus.req_cmd[ADDR_W+3:ADDR_W];
  assign w_addr      = bus.req_cmd[ADDR_W-1:0];
  assign w_size_ok   = (w_size <= 4'd3);
  assign w_req_fire  = bus.req_valid && bus.req_ready;
  assign w_wr_be     = bus.wr_beat[DATA_W+BE_W-1:DATA_W];
  assign w_wr_fire   = bus.wr_valid && bus.wr_ready;
  assign w_last_beat = ((r_cnt + 5'd1) == r_beats);
  assign w_credit_ok = ({1'b0, r_credits} + CW1'(r_beats)) <= CW1'(RSP_DEPTH);
  assign w_reserve   = (r_state == S_RCHK) && w_credit_ok;
  assign w_need      = CNT_W'(r_beats);
  assign w_pop       = !bus.pim_rd_empty && (r_outst != '0);
  assign w_rsp_valid = (r_wptr != r_rptr);
  assign w_rsp_fire  = w_rsp_valid && bus.rsp_ready;

  // Bad size codes keep req_ready low so the offending command stalls.
  assign bus.req_ready   = (r_state == S_IDLE) && w_size_ok;
  assign bus.wr_ready    = (r_state == S_WFILL) && !bus.pim_wr_almost_full;
  assign bus.pim_wr_push = w_wr_fire;
  assign bus.pim_wr_data = w_wr_fire ? bus.wr_beat[DATA_W-1:0] : '0;
  assign bus.pim_wr_be   = w_wr_fire ? w_wr_be : '0;
  assign bus.pim_addr    = r_addr;
  assign bus.pim_rnw     = r_rnw;
  assign bus.pim_size    = r_size;
  assign bus.pim_addr_req = r_addr_req;
  assign bus.pim_flush   = r_flush;
  assign bus.pim_rd_pop  = w_pop;
  assign bus.rsp_valid   = w_rsp_valid;
  assign bus.rsp_data    = w_rsp_valid ? r_mem[r_rptr[PTR_W-1:0]] : '0;
  assign o_dbg_state     = r_state;

  // Main sequencer: latch command, stage write beats or reserve credits, then AddrReq.
  always_ff @(posedge sys_clk_pin or posedge DDR_SDRAM_MPMC_Rst_pin) begin
    if (DDR_SDRAM_MPMC_Rst_pin) begin
      r_state    <= S_INIT;
      r_addr     <= '0;
      r_rnw      <= 1'b0;
      r_size     <= '0;
      r_beats    <= '0;
      r_cnt      <= '0;
      r_addr_req <= 1'b0;
      r_lat      <= '0;
    end else begin
      case (r_state)
        S_INIT: if (bus.pim_init_done) begin
          r_lat   <= bus.pim_rd_latency;
          r_state <= S_IDLE;
        end
        S_IDLE: if (w_req_fire) begin
          r_addr  <= w_addr;
          r_rnw   <= w_rnw;
          r_size  <= w_size;
          r_beats <= beats_of(w_size);
          r_cnt   <= '0;
          r_state <= w_rnw ? S_RCHK : S_WFILL;
        end
        S_WFILL: if (w_wr_fire) begin
          r_cnt <= r_cnt + 5'd1;
          if (w_last_beat) begin
            r_addr_req <= 1'b1;
            r_state    <= S_ADDR;
          end
        end
        S_RCHK: if (w_credit_ok) begin
          r_addr_req <= 1'b1;
          r_state    <= S_ADDR;
        end
        S_ADDR: if (bus.pim_addr_ack) begin
          r_addr_req <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

`ifdef DDR_PIM_RMW_EN
  logic r_rdmodwr;

  // Flag a partial single-beat write as read-modify-write for its AddrReq.
  always_ff @(posedge sys_clk_pin or posedge DDR_SDRAM_MPMC_Rst_pin) begin
    if (DDR_SDRAM_MPMC_Rst_pin) begin
      r_rdmodwr <= 1'b0;
    end else if (r_state == S_WFILL && w_wr_fire && w_last_beat) begin
      r_rdmodwr <= (r_size == 4'd0) && (w_wr_be != '1);
    end else if (r_state == S_ADDR && bus.pim_addr_ack) begin
      r_rdmodwr <= 1'b0;
    end
  end

  assign bus.pim_rdmodwr = r_rdmodwr;
`else
  assign bus.pim_rdmodwr = 1'b0;
`endif

  // Flush both PIM FIFOs during reset and for the first cycle after it.
  always_ff @(posedge sys_clk_pin or posedge DDR_SDRAM_MPMC_Rst_pin) begin
    if (DDR_SDRAM_MPMC_Rst_pin) r_flush <= 1'b1;
    else                        r_flush <= 1'b0;
  end

  // Credits track response FIFO slots promised to issued reads; outstanding
  // counts beats still to be popped from the PIM read FIFO.
  always_ff @(posedge sys_clk_pin or posedge DDR_SDRAM_MPMC_Rst_pin) begin
    if (DDR_SDRAM_MPMC_Rst_pin) begin
      r_outst   <= '0;
      r_credits <= '0;
    end else begin
      r_outst   <= r_outst + (w_reserve ? w_need : '0) - CNT_W'(w_pop);
      r_credits <= r_credits + (w_reserve ? w_need : '0) - CNT_W'(w_rsp_fire);
    end
  end

  // Pop tag shift line matching the PIM read data latency.
  always_ff @(posedge sys_clk_pin or posedge DDR_SDRAM_MPMC_Rst_pin) begin
    if (DDR_SDRAM_MPMC_Rst_pin) r_tag <= '0;
    else                        r_tag <= {r_tag[2:1], w_pop};
  end

  // Select the tap where popped data becomes valid on pim_rd_data.
  always_comb begin
    w_rsp_we = 1'b0;
    case (r_lat)
      2'd0:    w_rsp_we = w_pop;
      2'd1:    w_rsp_we = r_tag[1];
      2'd2:    w_rsp_we = r_tag[2];
      default: w_rsp_we = r_tag[3];
    endcase
  end

  // Response FIFO storage.
  always_ff @(posedge sys_clk_pin) begin
    if (w_rsp_we) r_mem[r_wptr[PTR_W-1:0]] <= bus.pim_rd_data;
  end

  // Response FIFO pointers; fall-through read side.
  always_ff @(posedge sys_clk_pin or posedge DDR_SDRAM_MPMC_Rst_pin) begin
    if (DDR_SDRAM_MPMC_Rst_pin) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_rsp_we)   r_wptr <= r_wptr + 1'b1;
      if (w_rsp_fire) r_rptr <= r_rptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_ddr_pim_burst_ctrl.sv
// Directed bench for ddr_pim_burst_ctrl with a PIM port model and scoreboard
// queues for write beats, PIM commands and read responses.
module tb_ddr_pim_burst_ctrl;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam logic RMW_EXP =
`ifdef DDR_PIM_RMW_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] dbg_state;
  int checks = 0;
  int failures = 0;

  ddr_pim_burst_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ddr_pim_burst_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RSP_DEPTH(16)) dut (
    .sys_clk_pin            (clk),
    .DDR_SDRAM_MPMC_Rst_pin (rst),
    .bus                    (bus),
    .o_dbg_state            (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  // scoreboards
  logic [71:0] exp_wr_q[$];
  logic [37:0] exp_cmd_q[$];
  logic [63:0] exp_rsp_q[$];
  int n_push = 0;
  int n_rsp = 0;
  int req_run = 0;
  int last_req_len = 0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int tb_beats(input logic [3:0] size);
    case (size)
      4'd0: return 1;
      4'd1: return 2;
      4'd2: return 4;
      4'd3: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] rd_word(input logic [31:0] addr, input int i);
    return {addr, 32'hC0DE_0000 + 32'(i)};
  endfunction

  // PIM model: delayed AddrAck, read FIFO filled on each read command.
  int ack_dly = 1;
  int ack_cnt;
  int rd_w, rd_r;
  logic [63:0] pim_mem [256];
  logic [63:0] dpipe1, dpipe2, dpipe3;

  assign bus.pim_rd_empty = (rd_w == rd_r);
  assign bus.pim_rd_data  = (bus.pim_rd_latency == 2'd0) ? pim_mem[rd_r[7:0]] :
                            (bus.pim_rd_latency == 2'd1) ? dpipe1 :
                            (bus.pim_rd_latency == 2'd2) ? dpipe2 : dpipe3;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.pim_addr_ack <= 1'b0;
      ack_cnt <= 0;
      rd_w <= 0;
      rd_r <= 0;
    end else begin
      if (bus.pim_addr_ack) begin
        bus.pim_addr_ack <= 1'b0;
        if (bus.pim_addr_req && bus.pim_rnw) begin
          for (int i = 0; i < tb_beats(bus.pim_size); i++)
            pim_mem[8'(rd_w + i)] <= rd_word(bus.pim_addr, i);
          rd_w <= rd_w + tb_beats(bus.pim_size);
        end
      end else if (bus.pim_addr_req) begin
        if (ack_cnt >= ack_dly - 1) begin
          bus.pim_addr_ack <= 1'b1;
          ack_cnt <= 0;
        end else begin
          ack_cnt <= ack_cnt + 1;
        end
      end
      if (bus.pim_rd_pop) begin
        dpipe1 <= pim_mem[rd_r[7:0]];
        rd_r <= rd_r + 1;
      end
      dpipe2 <= dpipe1;
      dpipe3 <= dpipe2;
    end
  end

  // Monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      req_run = 0;
    end else begin
      if (bus.pim_wr_push) begin
        n_push++;
        chk("wr_expected", (exp_wr_q.size() != 0), 1);
        if (exp_wr_q.size() != 0)
          chk("wr_beat", {bus.pim_wr_be, bus.pim_wr_data}, exp_wr_q.pop_front());
      end
      if (bus.pim_addr_req) req_run++;
      if (bus.pim_addr_req && bus.pim_addr_ack) begin
        last_req_len = req_run;
        req_run = 0;
        chk("cmd_expected", (exp_cmd_q.size() != 0), 1);
        if (exp_cmd_q.size() != 0)
          chk("pim_cmd", {bus.pim_rdmodwr, bus.pim_rnw, bus.pim_size, bus.pim_addr},
              exp_cmd_q.pop_front());
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_rsp++;
        chk("rsp_expected", (exp_rsp_q.size() != 0), 1);
        if (exp_rsp_q.size() != 0)
          chk("rsp_data", bus.rsp_data, exp_rsp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic rnw, input logic [3:0] size, input logic [31:0] addr);
    bit ok = 1'b0;
    bus.req_cmd = {rnw, size, addr};
    bus.req_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.req_ready;
      tick();
    end
    bus.req_valid = 1'b0;
    chk("req_accept", ok, 1);
  endtask

  task automatic send_wr(input logic [63:0] d, input logic [7:0] be);
    bit ok = 1'b0;
    exp_wr_q.push_back({be, d});
    bus.wr_beat = {be, d};
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.wr_ready;
      tick();
    end
    bus.wr_valid = 1'b0;
    chk("wr_accept", ok, 1);
  endtask

  task automatic read_burst(input logic [31:0] addr);
    exp_cmd_q.push_back({1'b0, 1'b1, 4'd3, addr});
    for (int i = 0; i < 8; i++) exp_rsp_q.push_back(rd_word(addr, i));
    send_req(1'b1, 4'd3, addr);
  endtask

  task automatic consume(input int k);
    int n = 0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 200 && n < k; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) n++;
      tick();
    end
    bus.rsp_ready = 1'b0;
    chk("consume_count", n, k);
  endtask

  task automatic wait_done(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      tick();
      done = (exp_cmd_q.size() == 0) && (exp_rsp_q.size() == 0) && (dbg_state == 3'd1);
    end
    chk(tag, done, 1);
  endtask

  task automatic do_reset(input logic [1:0] lat);
    rst = 1'b1;
    bus.pim_init_done = 1'b0;
    bus.pim_rd_latency = lat;
    exp_wr_q.delete();
    exp_cmd_q.delete();
    exp_rsp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    bus.pim_init_done = 1'b1;
    repeat (2) tick();
    chk("reinit_req_ready", bus.req_ready, 1);
  endtask

  logic [63:0] d;
  logic [7:0]  be;
  int base;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_cmd = '0;
    bus.wr_valid = 1'b0;
    bus.wr_beat = '0;
    bus.rsp_ready = 1'b1;
    bus.pim_wr_almost_full = 1'b0;
    bus.pim_rd_latency = 2'd0;
    bus.pim_init_done = 1'b0;
    #1 rst = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_flush", bus.pim_flush, 1);
    chk("rst_addr_req", bus.pim_addr_req, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rd_pop", bus.pim_rd_pop, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("flush_after_release", bus.pim_flush, 1);
    @(negedge clk);
    chk("flush_cleared", bus.pim_flush, 0);
    chk("init_req_ready", bus.req_ready, 0);
    chk("init_state", dbg_state, 3'd0);
    tick();
    bus.pim_init_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle_req_ready", bus.req_ready, 1);
    tick();

    // illegal size code stalls
    bus.req_cmd = {1'b1, 4'd5, 32'h0000_0500};
    bus.req_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("bad_size_ready", bus.req_ready, 0);
    chk("bad_size_state", dbg_state, 3'd1);
    tick();
    bus.req_valid = 1'b0;
    tick();

    // 4-beat write, almost-full stall on beat 2, ack delayed 5 cycles
    ack_dly = 5;
    exp_cmd_q.push_back({1'b0, 1'b0, 4'd2, 32'h0000_1000});
    send_req(1'b0, 4'd2, 32'h0000_1000);
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom};
      be = 8'($urandom_range(1, 255));
      if (i == 2) begin
        bus.wr_beat = {be, d};
        bus.wr_valid = 1'b1;
        bus.pim_wr_almost_full = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("af_wr_ready", bus.wr_ready, 0);
          chk("af_no_push", bus.pim_wr_push, 0);
        end
        tick();
        bus.pim_wr_almost_full = 1'b0;
      end
      send_wr(d, be);
    end
    wait_done("write_done");
    chk("addr_req_len", last_req_len, 6);
    chk("push_count", n_push, 4);
    chk("wr_q_empty", exp_wr_q.size(), 0);
    ack_dly = 1;

    // 8-beat read at latency 0
    base = n_rsp;
    read_burst(32'h0000_2000);
    wait_done("read_lat0_done");
    chk("rsp_count_lat0", n_rsp - base, 8);

    // 8-beat reads at latency 1..3
    for (int l = 1; l < 4; l++) begin
      do_reset(2'(l));
      base = n_rsp;
      read_burst(32'h0000_3000 + 32'(l) * 32'h100);
      wait_done("read_lat_done");
      chk("rsp_count_lat", n_rsp - base, 8);
    end

    // credit stall: third 8-beat read waits until 8 responses are consumed
    bus.rsp_ready = 1'b0;
    read_burst(32'h0000_5000);
    read_burst(32'h0000_5100);
    read_burst(32'h0000_5200);
    repeat (30) tick();
    chk("rchk_state", dbg_state, 3'd3);
    chk("rchk_pending_cmd", exp_cmd_q.size(), 1);
    chk("rchk_no_addr_req", bus.pim_addr_req, 0);
    consume(7);
    repeat (10) tick();
    chk("rchk_hold_after7", dbg_state, 3'd3);
    consume(1);
    repeat (6) tick();
    chk("rchk_released", exp_cmd_q.size(), 0);
    bus.rsp_ready = 1'b1;
    wait_done("rchk_drain");

    // single-beat partial and full writes
    exp_cmd_q.push_back({RMW_EXP, 1'b0, 4'd0, 32'h0000_4000});
    send_req(1'b0, 4'd0, 32'h0000_4000);
    send_wr(64'h1122_3344_5566_7788, 8'h0F);
    wait_done("rmw_partial_done");
    exp_cmd_q.push_back({1'b0, 1'b0, 4'd0, 32'h0000_4008});
    send_req(1'b0, 4'd0, 32'h0000_4008);
    send_wr(64'h99AA_BBCC_DDEE_FF00, 8'hFF);
    wait_done("rmw_full_done");
    chk("final_wr_q_empty", exp_wr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
